bp_ras_ctrl: RTL and testbench

Front-end controller that drives the return address stack (RAS) from the fetch side. It classifies each fetched instruction as call, return, coroutine swap or none, using the RISC-V link-register hint rules. It issues the matching push/pop commands to the RAS and, for returns, returns a registered predicted target to fetch over a valid/ready handshake. It sits between fetch/pre-decode and the RAS, opposite the consumer side of the stack.

---
 rtl/bp_ras_ctrl_pkg.sv | 36 +++
 rtl/bp_ras_ctrl_if.sv | 37 +++
 rtl/bp_ras_decode.sv | 70 +++++++
 rtl/bp_ras_ctrl.sv | 126 ++++++++++++
 tb/tb_bp_ras_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_ras_ctrl_pkg.sv
// ==========================================================================
// bp_pkg : shared types and encodings for the RAS front-end controller
// Revision: 1.0
// ==========================================================================
`default_nettype none

package bp_pkg;

  typedef enum logic [1:0] {
    RAS_NONE    = 2'd0,
    RAS_PUSH    = 2'd1,
    RAS_POP     = 2'd2,
    RAS_POPPUSH = 2'd3
  } ras_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_PUSH2 = 2'd2,
    ST_WAIT  = 2'd3
  } ctrl_state_e;

  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [3:0] C_FUNCT4_JR   = 4'b1000;
  localparam logic [3:0] C_FUNCT4_JALR = 4'b1001;
  localparam logic [4:0] LINK_X1       = 5'd1;
  localparam logic [4:0] LINK_X5       = 5'd5;

  function automatic logic is_link(input logic [4:0] r, input logic alt_en);
    return (r == LINK_X1) || (alt_en && (r == LINK_X5));
  endfunction

endpackage

`default_nettype wire

// File: rtl/bp_ras_ctrl_if.sv
// ==========================================================================
// bp_ras_ctrl_if : fetch, RAS and prediction signals of the RAS controller
// Revision: 1.0
// ==========================================================================
`default_nettype none

interface bp_ras_ctrl_if;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] instr_i;
  logic [63:0] pc_i;
  logic        flush_i;
  logic        ras_push_o;
  logic [63:0] ras_push_addr_o;
  logic        ras_pop_o;
  logic [63:0] ras_pop_addr_i;
  logic        ras_empty_i;
  logic        pred_valid_o;
  logic        pred_ready_i;
  logic [63:0] pred_target_o;
  logic        pred_hit_o;

  // master is the controller's view; slave is fetch plus the RAS
  modport master (
    input  instr_valid_i, instr_i, pc_i, flush_i, ras_pop_addr_i, ras_empty_i, pred_ready_i,
    output instr_ready_o, ras_push_o, ras_push_addr_o, ras_pop_o,
           pred_valid_o, pred_target_o, pred_hit_o
  );

  modport slave (
    output instr_valid_i, instr_i, pc_i, flush_i, ras_pop_addr_i, ras_empty_i, pred_ready_i,
    input  instr_ready_o, ras_push_o, ras_push_addr_o, ras_pop_o,
           pred_valid_o, pred_target_o, pred_hit_o
  );
endinterface

`default_nettype wire

// File: rtl/bp_ras_decode.sv
// ==========================================================================
// bp_ras_decode : combinational call/return classifier using link-reg hints
// Revision: 1.0
// ==========================================================================
`default_nettype none

module bp_ras_decode
  import bp_pkg::*;
#(
  parameter bit RVC_EN      = 1'b1,
  parameter bit ALT_LINK_EN = 1'b1
) (
  input  logic [31:0] instr_i,
  input  logic [63:0] pc_i,
  output ras_op_e     kind_o,
  output logic [63:0] link_addr_o
);

  logic       is_rvc;
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [3:0] c_funct4;
  logic [4:0] c_rs1;
  logic [4:0] c_rs2;
  logic       rd_link;
  logic       rs1_link;
  logic       c_rs1_link;
  logic       unused_bits;

  assign is_rvc     = (instr_i[1:0] != 2'b11);
  assign opcode     = instr_i[6:0];
  assign rd         = instr_i[11:7];
  assign rs1        = instr_i[19:15];
  assign c_funct4   = instr_i[15:12];
  assign c_rs1      = instr_i[11:7];
  assign c_rs2      = instr_i[6:2];
  assign rd_link    = is_link(rd, ALT_LINK_EN);
  assign rs1_link   = is_link(rs1, ALT_LINK_EN);
  assign c_rs1_link = is_link(c_rs1, ALT_LINK_EN);
  assign unused_bits = ^instr_i[31:20];

  assign link_addr_o = pc_i + (is_rvc ? 64'd2 : 64'd4);

  always_comb begin
    kind_o = RAS_NONE;
    if (!is_rvc) begin
      if (opcode == OPC_JAL) begin
        if (rd_link) kind_o = RAS_PUSH;
      end else if (opcode == OPC_JALR) begin
        unique case ({rd_link, rs1_link})
          2'b10:   kind_o = RAS_PUSH;
          2'b01:   kind_o = RAS_POP;
          2'b11:   kind_o = (rd != rs1) ? RAS_POPPUSH : RAS_PUSH;
          default: kind_o = RAS_NONE;
        endcase
      end
    end else if (RVC_EN && (instr_i[1:0] == 2'b10) && (c_rs2 == 5'd0) && (c_rs1 != 5'd0)) begin
      // C.JALR always links through x1, so only an x5 source makes it a swap
      if (c_funct4 == C_FUNCT4_JR) begin
        if (c_rs1_link) kind_o = RAS_POP;
      end else if (c_funct4 == C_FUNCT4_JALR) begin
        kind_o = (ALT_LINK_EN && (c_rs1 == LINK_X5)) ? RAS_POPPUSH : RAS_PUSH;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bp_ras_ctrl.sv
// ==========================================================================
// bp_ras_ctrl : issues RAS push/pop commands and returns predicted targets
// Revision: 1.0
// ==========================================================================
`default_nettype none

module bp_ras_ctrl
  import bp_pkg::*;
#(
  parameter bit RVC_EN      = 1'b1,
  parameter bit ALT_LINK_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  bp_ras_ctrl_if.master bus
);

  ctrl_state_e state_q, state_d;
  ras_op_e     kind_q, kind_d, dec_kind;
  logic [63:0] link_q, link_d, dec_link;
  logic        pred_valid_q, pred_valid_d;
  logic [63:0] pred_target_q, pred_target_d;
  logic        pred_hit_q, pred_hit_d;
  logic        instr_ready;
  logic        ras_push;
  logic        ras_pop;
  logic        pred_fire;

  bp_ras_decode #(
    .RVC_EN      (RVC_EN),
    .ALT_LINK_EN (ALT_LINK_EN)
  ) u_decode (
    .instr_i     (bus.instr_i),
    .pc_i        (bus.pc_i),
    .kind_o      (dec_kind),
    .link_addr_o (dec_link)
  );

  assign pred_fire = pred_valid_q & bus.pred_ready_i;

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    link_d        = link_q;
    pred_valid_d  = pred_valid_q;
    pred_target_d = pred_target_q;
    pred_hit_d    = pred_hit_q;
    instr_ready   = 1'b0;
    ras_push      = 1'b0;
    ras_pop       = 1'b0;

    if (bus.flush_i) begin
      state_d      = ST_IDLE;
      pred_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          instr_ready = 1'b1;
          if (bus.instr_valid_i && (dec_kind != RAS_NONE)) begin
            kind_d  = dec_kind;
            link_d  = dec_link;
            state_d = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (kind_q == RAS_PUSH) begin
            ras_push = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            // pop goes out even on an empty stack; the RAS drops it
            ras_pop       = 1'b1;
            pred_target_d = bus.ras_empty_i ? 64'd0 : bus.ras_pop_addr_i;
            pred_hit_d    = ~bus.ras_empty_i;
            pred_valid_d  = 1'b1;
            state_d       = (kind_q == RAS_POPPUSH) ? ST_PUSH2 : ST_WAIT;
          end
        end
        ST_PUSH2: begin
          ras_push = 1'b1;
          if (pred_fire) begin
            pred_valid_d = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            state_d      = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (pred_fire) begin
            pred_valid_d = 1'b0;
            state_d      = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      kind_q        <= RAS_NONE;
      link_q        <= 64'd0;
      pred_valid_q  <= 1'b0;
      pred_target_q <= 64'd0;
      pred_hit_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      link_q        <= link_d;
      pred_valid_q  <= pred_valid_d;
      pred_target_q <= pred_target_d;
      pred_hit_q    <= pred_hit_d;
    end
  end

  assign bus.instr_ready_o   = instr_ready;
  assign bus.ras_push_o      = ras_push;
  assign bus.ras_push_addr_o = link_q;
  assign bus.ras_pop_o       = ras_pop;
  assign bus.pred_valid_o    = pred_valid_q;
  assign bus.pred_target_o   = pred_target_q;
  assign bus.pred_hit_o      = pred_hit_q;

endmodule

`default_nettype wire

// File: tb/tb_bp_ras_ctrl.sv
// ==========================================================================
// tb_bp_ras_ctrl : scoreboard bench for the RAS front-end controller
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_bp_ras_ctrl;
  import bp_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bp_ras_ctrl_if bus ();

  bp_ras_ctrl #(
    .RVC_EN      (1'b1),
    .ALT_LINK_EN (1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    bit          is_push;
    logic [63:0] addr;
  } cmd_t;

  typedef struct {
    logic [63:0] target;
    logic        hit;
  } pred_t;

  cmd_t  cmd_q[$];
  pred_t pred_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // monitor: consumes expectations whenever the DUT commands the RAS or hands off a prediction
  initial begin
    cmd_t  c;
    pred_t p;
    forever begin
      @(negedge clk);
      #2;
      chk("push_pop_exclusive", 64'(bus.ras_push_o & bus.ras_pop_o), 64'd0);
      if (bus.ras_push_o || bus.ras_pop_o) begin
        if (cmd_q.size() == 0) begin
          chk("unexpected_cmd", {62'd0, bus.ras_push_o, bus.ras_pop_o}, 64'd0);
        end else begin
          c = cmd_q.pop_front();
          chk("cmd_is_push", 64'(bus.ras_push_o), 64'(c.is_push));
          if (c.is_push) chk("push_addr", bus.ras_push_addr_o, c.addr);
        end
      end
      if (bus.pred_valid_o && bus.pred_ready_i) begin
        if (pred_q.size() == 0) begin
          chk("unexpected_pred", 64'(bus.pred_valid_o), 64'd0);
        end else begin
          p = pred_q.pop_front();
          chk("pred_target", bus.pred_target_o, p.target);
          chk("pred_hit", 64'(bus.pred_hit_o), 64'(p.hit));
        end
      end
    end
  end

  task automatic exp_pop(input logic [63:0] top, input logic emp, input bit with_pred);
    cmd_t  c;
    pred_t p;
    c.is_push = 1'b0;
    c.addr    = 64'd0;
    cmd_q.push_back(c);
    if (with_pred) begin
      p.target = emp ? 64'd0 : top;
      p.hit    = ~emp;
      pred_q.push_back(p);
    end
  endtask

  task automatic exp_push(input logic [63:0] lnk);
    cmd_t c;
    c.is_push = 1'b1;
    c.addr    = lnk;
    cmd_q.push_back(c);
  endtask

  task automatic present(input logic [31:0] ins, input logic [63:0] pc,
                         input logic [63:0] top, input logic emp);
    bus.instr_valid_i  = 1'b1;
    bus.instr_i        = ins;
    bus.pc_i           = pc;
    bus.ras_pop_addr_i = top;
    bus.ras_empty_i    = emp;
  endtask

  // one instruction with fetch always ready for the prediction
  task automatic run_instr(input string name, input logic [31:0] ins, input logic [63:0] pc,
                           input ras_op_e k, input logic [63:0] lnk,
                           input logic [63:0] top, input logic emp);
    bit is_pop;
    bit done;
    is_pop = (k == RAS_POP) || (k == RAS_POPPUSH);
    if (is_pop) exp_pop(top, emp, 1'b1);
    if ((k == RAS_PUSH) || (k == RAS_POPPUSH)) exp_push(lnk);

    @(negedge clk);
    present(ins, pc, top, emp);
    #2 chk({name, "_accept"}, 64'(bus.instr_ready_o), 64'd1);
    @(negedge clk);
    bus.instr_valid_i = 1'b0;
    #2;
    chk({name, "_n1_push"}, 64'(bus.ras_push_o), 64'(k == RAS_PUSH));
    chk({name, "_n1_pop"}, 64'(bus.ras_pop_o), 64'(is_pop));
    @(negedge clk);
    #2;
    if (k == RAS_PUSH || k == RAS_NONE) begin
      chk({name, "_n2_ready"}, 64'(bus.instr_ready_o), 64'd1);
    end else begin
      chk({name, "_n2_pred_valid"}, 64'(bus.pred_valid_o), 64'd1);
      chk({name, "_n2_push"}, 64'(bus.ras_push_o), 64'(k == RAS_POPPUSH));
    end
    done = bus.instr_ready_o;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      #2 done = bus.instr_ready_o;
    end
    chk({name, "_back_to_idle"}, 64'(bus.instr_ready_o), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_valid_i  = 1'b0;
    bus.instr_i        = 32'd0;
    bus.pc_i           = 64'd0;
    bus.flush_i        = 1'b0;
    bus.ras_pop_addr_i = 64'd0;
    bus.ras_empty_i    = 1'b0;
    bus.pred_ready_i   = 1'b1;

    @(negedge clk);
    #2;
    chk("rst_ready", 64'(bus.instr_ready_o), 64'd1);
    chk("rst_push", 64'(bus.ras_push_o), 64'd0);
    chk("rst_pop", 64'(bus.ras_pop_o), 64'd0);
    chk("rst_pred_valid", 64'(bus.pred_valid_o), 64'd0);
    chk("rst_pred_target", bus.pred_target_o, 64'd0);
    chk("rst_push_addr", bus.ras_push_addr_o, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_instr("jal_x1",     32'h0000_00EF, 64'h0000_0000_8000_0000, RAS_PUSH,    64'h8000_0004, 64'd0,      1'b0);
    run_instr("ret_hit",    32'h0000_8067, 64'h1000, RAS_POP,     64'd0,      64'h1234, 1'b0);
    run_instr("ret_empty",  32'h0000_8067, 64'h1000, RAS_POP,     64'd0,      64'h5555, 1'b1);
    run_instr("cjalr_x5",   32'h0000_9282, 64'h100,  RAS_POPPUSH, 64'h102,    64'hABC,  1'b0);
    run_instr("jalr_x1_x5", 32'h0002_80E7, 64'h2000, RAS_POPPUSH, 64'h2004,   64'h4444, 1'b0);
    run_instr("jalr_x5_x5", 32'h0002_82E7, 64'h2100, RAS_PUSH,    64'h2104,   64'd0,    1'b0);
    run_instr("jal_wrap",   32'h0000_00EF, 64'hFFFF_FFFF_FFFF_FFFC, RAS_PUSH, 64'd0, 64'd0, 1'b0);
    run_instr("jal_x0",     32'h0000_006F, 64'h10,   RAS_NONE,    64'd0,      64'd0,    1'b0);
    run_instr("cjr_x1",     32'h0000_8082, 64'h40,   RAS_POP,     64'd0,      64'h9999, 1'b0);
    run_instr("cjalr_x1",   32'h0000_9082, 64'h50,   RAS_PUSH,    64'h52,     64'd0,    1'b0);
    run_instr("addi",       32'h0000_0013, 64'h60,   RAS_NONE,    64'd0,      64'd0,    1'b0);
    run_instr("cjr_x2",     32'h0000_8102, 64'h70,   RAS_NONE,    64'd0,      64'd0,    1'b0);

    // return held off by fetch for three cycles
    bus.pred_ready_i = 1'b0;
    exp_pop(64'h2222_0000_0000_5678, 1'b0, 1'b1);
    @(negedge clk);
    present(32'h0000_8067, 64'h3000, 64'h2222_0000_0000_5678, 1'b0);
    #2 chk("stall_accept", 64'(bus.instr_ready_o), 64'd1);
    @(negedge clk);
    bus.instr_valid_i = 1'b0;
    #2 chk("stall_pop", 64'(bus.ras_pop_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.ras_pop_addr_i = 64'hDEAD_0000 + 64'(i);
      #2;
      chk("stall_pred_valid", 64'(bus.pred_valid_o), 64'd1);
      chk("stall_pred_target", bus.pred_target_o, 64'h2222_0000_0000_5678);
      chk("stall_pred_hit", 64'(bus.pred_hit_o), 64'd1);
      chk("stall_ready_low", 64'(bus.instr_ready_o), 64'd0);
    end
    @(negedge clk);
    bus.pred_ready_i = 1'b1;
    #2 chk("stall_handshake_ready_low", 64'(bus.instr_ready_o), 64'd0);
    @(negedge clk);
    #2;
    chk("stall_idle_ready", 64'(bus.instr_ready_o), 64'd1);
    chk("stall_idle_pred_valid", 64'(bus.pred_valid_o), 64'd0);

    // flush while the second half of a swap is due
    bus.pred_ready_i = 1'b0;
    exp_pop(64'h300, 1'b0, 1'b0);
    @(negedge clk);
    present(32'h0000_9282, 64'h200, 64'h300, 1'b0);
    #2 chk("flush_accept", 64'(bus.instr_ready_o), 64'd1);
    @(negedge clk);
    bus.instr_valid_i = 1'b0;
    #2 chk("flush_pop", 64'(bus.ras_pop_o), 64'd1);
    @(negedge clk);
    bus.flush_i = 1'b1;
    #2;
    chk("flush_no_push", 64'(bus.ras_push_o), 64'd0);
    chk("flush_ready_push2", 64'(bus.instr_ready_o), 64'd0);
    @(negedge clk);
    present(32'h0000_00EF, 64'h900, 64'd0, 1'b0);
    #2;
    chk("flush_pred_cleared", 64'(bus.pred_valid_o), 64'd0);
    chk("flush_idle_not_ready", 64'(bus.instr_ready_o), 64'd0);
    @(negedge clk);
    bus.flush_i       = 1'b0;
    bus.instr_valid_i = 1'b0;
    #2;
    chk("flush_after_no_push", 64'(bus.ras_push_o), 64'd0);
    chk("flush_after_ready", 64'(bus.instr_ready_o), 64'd1);

    // asynchronous reset while waiting on a prediction
    exp_pop(64'h777, 1'b0, 1'b0);
    @(negedge clk);
    present(32'h0000_8067, 64'h3000, 64'h777, 1'b0);
    @(negedge clk);
    bus.instr_valid_i = 1'b0;
    @(negedge clk);
    #2 chk("arst_pre_pred_valid", 64'(bus.pred_valid_o), 64'd1);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_pred_valid", 64'(bus.pred_valid_o), 64'd0);
    chk("arst_pred_target", bus.pred_target_o, 64'd0);
    chk("arst_pred_hit", 64'(bus.pred_hit_o), 64'd0);
    chk("arst_push_addr", bus.ras_push_addr_o, 64'd0);
    chk("arst_cmds", {62'd0, bus.ras_push_o, bus.ras_pop_o}, 64'd0);
    chk("arst_ready", 64'(bus.instr_ready_o), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    bus.pred_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    chk("cmd_queue_drained", 64'(cmd_q.size()), 64'd0);
    chk("pred_queue_drained", 64'(pred_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
